// File: rtl/button_event_decoder.sv
// Pushbutton front end: synchronise, debounce on a 1 ms timebase, and classify
// presses as short, long or double with a held event code and duration.
module button_event_decoder #(
   parameter int unsigned TERMINAL_CNT_1MS = 11999,
   parameter int unsigned DEBOUNCE_MS      = 20,
   parameter int unsigned LONG_PRESS_MS    = 1000,
   parameter int unsigned DOUBLE_GAP_MS    = 300,
   parameter bit          BTN_ACTIVE_LOW   = 1'b1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_in,
   output logic        btn_state,
   output logic        evt_valid,
   output logic [1:0]  evt_code,
   output logic [11:0] evt_duration,
   output logic [7:0]  evt_count
);

   localparam int unsigned TW = (TERMINAL_CNT_1MS > 0) ? $clog2(TERMINAL_CNT_1MS + 1) : 1;
   localparam logic [TW-1:0] TERM     = TW'(TERMINAL_CNT_1MS);
   localparam logic [7:0]    DB_LAST  = 8'(DEBOUNCE_MS - 1);
   localparam logic [11:0]   LONG_TH  = 12'(LONG_PRESS_MS);
   localparam logic [11:0]   GAP_LAST = 12'(DOUBLE_GAP_MS - 1);
   localparam logic          RELEASED = BTN_ACTIVE_LOW;
   localparam bit            DBL_EN   = (DOUBLE_GAP_MS != 0);

   localparam logic [1:0] CODE_NONE   = 2'b00;
   localparam logic [1:0] CODE_SHORT  = 2'b01;
   localparam logic [1:0] CODE_LONG   = 2'b10;
   localparam logic [1:0] CODE_DOUBLE = 2'b11;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_PRESS1 = 2'd1,
      S_GAP    = 2'd2,
      S_PRESS2 = 2'd3
   } state_t;

   logic          sync1, sync2, btn_sync;
   logic [TW-1:0] ms_cnt;
   logic          tick_1ms;
   logic [7:0]    db_cnt;
   logic          db_differ, toggle, rise, fall;
   logic [11:0]   dur_cnt, gap_cnt, saved_dur;
   state_t        state_q, state_d;
   logic          emit, dur_clr, gap_clr, save_dur, gap_expire;
   logic [1:0]    emit_code;
   logic [11:0]   emit_dur;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= RELEASED;
         sync2 <= RELEASED;
      end else begin
         sync1 <= btn_in;
         sync2 <= sync1;
      end
   end

   assign btn_sync = sync2 ^ RELEASED;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           ms_cnt <= '0;
      else if (tick_1ms) ms_cnt <= '0;
      else               ms_cnt <= ms_cnt + 1'b1;
   end

   assign tick_1ms = (ms_cnt == TERM);

   // rise/fall coincide with the accepting tick so they can race gap expiry
   assign db_differ = btn_sync ^ btn_state;
   assign toggle    = tick_1ms & db_differ & (db_cnt == DB_LAST);
   assign rise      = toggle & ~btn_state;
   assign fall      = toggle & btn_state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_cnt    <= '0;
         btn_state <= 1'b0;
      end else if (tick_1ms) begin
         if (!db_differ || toggle) db_cnt <= '0;
         else                      db_cnt <= db_cnt + 1'b1;
         if (toggle) btn_state <= ~btn_state;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dur_cnt   <= '0;
         gap_cnt   <= '0;
         saved_dur <= '0;
      end else begin
         if (dur_clr)                            dur_cnt <= '0;
         else if (tick_1ms && (dur_cnt != '1))   dur_cnt <= dur_cnt + 1'b1;
         if (gap_clr)                            gap_cnt <= '0;
         else if (tick_1ms && (gap_cnt != '1))   gap_cnt <= gap_cnt + 1'b1;
         if (save_dur)                           saved_dur <= dur_cnt;
      end
   end

   assign gap_expire = DBL_EN && tick_1ms && (gap_cnt >= GAP_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d   = state_q;
      emit      = 1'b0;
      emit_code = CODE_NONE;
      emit_dur  = dur_cnt;
      dur_clr   = 1'b0;
      gap_clr   = 1'b0;
      save_dur  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (rise) begin
               state_d = S_PRESS1;
               dur_clr = 1'b1;
            end
         end
         S_PRESS1: begin
            if (fall) begin
               save_dur = 1'b1;
               if (dur_cnt >= LONG_TH) begin
                  emit      = 1'b1;
                  emit_code = CODE_LONG;
                  state_d   = S_IDLE;
               end else if (!DBL_EN) begin
                  emit      = 1'b1;
                  emit_code = CODE_SHORT;
                  state_d   = S_IDLE;
               end else begin
                  gap_clr = 1'b1;
                  state_d = S_GAP;
               end
            end
         end
         S_GAP: begin
            if (rise) begin
               state_d = S_PRESS2;
               dur_clr = 1'b1;
            end else if (gap_expire) begin
               emit      = 1'b1;
               emit_code = CODE_SHORT;
               emit_dur  = saved_dur;
               state_d   = S_IDLE;
            end
         end
         S_PRESS2: begin
            if (fall) begin
               emit      = 1'b1;
               emit_code = CODE_DOUBLE;
               state_d   = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_valid    <= 1'b0;
         evt_code     <= CODE_NONE;
         evt_duration <= '0;
         evt_count    <= '0;
      end else begin
         evt_valid <= emit;
         if (emit) begin
            evt_code     <= emit_code;
            evt_duration <= emit_dur;
            evt_count    <= evt_count + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed self-checking bench for button_event_decoder.
module tb_button_event_decoder;

   logic        clk, rst, btn_in, btn_f;
   logic        btn_state, evt_valid;
   logic [1:0]  evt_code;
   logic [11:0] evt_duration;
   logic [7:0]  evt_count;
   logic        btn_state_f, evt_valid_f;
   logic [1:0]  evt_code_f;
   logic [11:0] evt_duration_f;
   logic [7:0]  evt_count_f;

   int unsigned checks = 0;
   int unsigned errors = 0;

   int unsigned cyc = 0, ev_n = 0, evf_n = 0;
   int unsigned n_short = 0, n_long = 0, n_double = 0;
   int unsigned last_ev_cyc = 0, last_fall_cyc = 0;
   logic        prev_state = 1'b0;
   int unsigned ev_snap;

   button_event_decoder #(
      .TERMINAL_CNT_1MS(9),
      .DEBOUNCE_MS(3),
      .LONG_PRESS_MS(50),
      .DOUBLE_GAP_MS(20),
      .BTN_ACTIVE_LOW(1'b1)
   ) u_dut (
      .clk(clk), .rst(rst), .btn_in(btn_in),
      .btn_state(btn_state), .evt_valid(evt_valid), .evt_code(evt_code),
      .evt_duration(evt_duration), .evt_count(evt_count)
   );

   // Fast, active-high, double-disabled instance for the count wrap
   button_event_decoder #(
      .TERMINAL_CNT_1MS(1),
      .DEBOUNCE_MS(1),
      .LONG_PRESS_MS(50),
      .DOUBLE_GAP_MS(0),
      .BTN_ACTIVE_LOW(1'b0)
   ) u_fast (
      .clk(clk), .rst(rst), .btn_in(btn_f),
      .btn_state(btn_state_f), .evt_valid(evt_valid_f), .evt_code(evt_code_f),
      .evt_duration(evt_duration_f), .evt_count(evt_count_f)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      prev_state <= btn_state;
      if (prev_state && !btn_state) last_fall_cyc <= cyc;
      if (evt_valid) begin
         ev_n <= ev_n + 1;
         last_ev_cyc <= cyc;
         if (evt_code == 2'b01) n_short  <= n_short + 1;
         if (evt_code == 2'b10) n_long   <= n_long + 1;
         if (evt_code == 2'b11) n_double <= n_double + 1;
      end
      if (evt_valid_f) evf_n <= evf_n + 1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic chk_rng(input string tag, input logic [31:0] obs,
                          input logic [31:0] lo, input logic [31:0] hi);
      checks++;
      assert (!$isunknown(obs) && obs >= lo && obs <= hi) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
      end
   endtask

   task automatic wait_ms(input int unsigned n);
      repeat (n * 10) @(posedge clk);
      #1;
   endtask

   task automatic press_for(input int unsigned ms);
      btn_in = 1'b0;
      wait_ms(ms);
      btn_in = 1'b1;
   endtask

   initial begin
      rst = 1'b1; btn_in = 1'b1; btn_f = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_btn_state", btn_state, 0);
      chk("rst_valid", evt_valid, 0);
      chk("rst_code", evt_code, 0);
      chk("rst_dur", evt_duration, 0);
      chk("rst_count", evt_count, 0);
      rst = 1'b0;

      // evt_count wrap on the fast instance
      for (int i = 0; i < 255; i++) begin
         btn_f = 1'b1; repeat (8) @(posedge clk); #1;
         btn_f = 1'b0; repeat (8) @(posedge clk); #1;
      end
      chk("wrap_count255", evt_count_f, 255);
      chk("wrap_events255", evf_n, 255);
      chk("wrap_code", evt_code_f, 2'b01);
      btn_f = 1'b1; repeat (8) @(posedge clk); #1;
      btn_f = 1'b0; repeat (8) @(posedge clk); #1;
      chk("wrap_count0", evt_count_f, 0);
      chk("wrap_events256", evf_n, 256);

      // 1: glitch of 2 ms is rejected
      wait_ms(5);
      press_for(2);
      wait_ms(10);
      chk("glitch_state", btn_state, 0);
      chk("glitch_events", ev_n, 0);
      chk("glitch_count", evt_count, 0);

      // 2: short press
      btn_in = 1'b0;
      wait_ms(10);
      chk("short_pressed", btn_state, 1);
      btn_in = 1'b1;
      wait_ms(30);
      chk("short_events", ev_n, 1);
      chk("short_code", evt_code, 2'b01);
      chk_rng("short_dur", evt_duration, 9, 11);
      chk("short_count", evt_count, 1);
      chk_rng("short_latency", last_ev_cyc - last_fall_cyc, 195, 205);
      chk("short_valid_low", evt_valid, 0);

      // 3: long press, then saturation
      press_for(60);
      wait_ms(30);
      chk("long_code", evt_code, 2'b10);
      chk_rng("long_dur", evt_duration, 59, 61);
      chk("long_count", evt_count, 2);
      wait_ms(30);
      chk("long_no_extra", ev_n, 2);
      press_for(5000);
      wait_ms(10);
      chk("sat_code", evt_code, 2'b10);
      chk("sat_dur", evt_duration, 4095);
      chk("sat_count", evt_count, 3);

      // 4: double press
      press_for(10);
      wait_ms(8);
      press_for(15);
      wait_ms(30);
      chk("dbl_events", ev_n, 4);
      chk("dbl_code", evt_code, 2'b11);
      chk_rng("dbl_dur", evt_duration, 14, 16);
      chk("dbl_count", evt_count, 4);
      chk("dbl_no_short", n_short, 1);

      // 5: rise on the expiry tick wins
      press_for(10);
      wait_ms(20);
      press_for(10);
      wait_ms(30);
      chk("edge_code", evt_code, 2'b11);
      chk("edge_doubles", n_double, 2);
      chk("edge_no_short", n_short, 1);
      chk("edge_count", evt_count, 5);

      press_for(10);
      wait_ms(21);
      press_for(10);
      wait_ms(30);
      chk("gap21_shorts", n_short, 3);
      chk("gap21_events", ev_n, 7);

      press_for(10);
      wait_ms(25);
      press_for(10);
      wait_ms(30);
      chk("gap25_shorts", n_short, 5);
      chk("gap25_code", evt_code, 2'b01);
      chk_rng("gap25_dur", evt_duration, 9, 11);
      chk("gap25_count", evt_count, 9);

      // 6: reset during PRESS2 discards the sequence
      press_for(10);
      wait_ms(5);
      btn_in = 1'b0;
      wait_ms(10);
      rst = 1'b1;
      #1;
      chk("mid_rst_state", btn_state, 0);
      chk("mid_rst_valid", evt_valid, 0);
      chk("mid_rst_code", evt_code, 0);
      chk("mid_rst_dur", evt_duration, 0);
      chk("mid_rst_count", evt_count, 0);
      ev_snap = ev_n;
      btn_in = 1'b1;
      wait_ms(5);
      rst = 1'b0;
      wait_ms(40);
      chk("mid_rst_no_event", ev_n, ev_snap);
      chk("mid_rst_count_after", evt_count, 0);

      // button held through reset release is a fresh press
      btn_in = 1'b0;
      wait_ms(10);
      rst = 1'b1;
      wait_ms(2);
      rst = 1'b0;
      wait_ms(15);
      chk("held_accepted", btn_state, 1);
      btn_in = 1'b1;
      wait_ms(30);
      chk("held_code", evt_code, 2'b01);
      chk_rng("held_dur", evt_duration, 12, 15);
      chk("held_count", evt_count, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
